sha256_avalon_sequencer: RTL and testbench
==========================================

SHA256_AVALON_SEQUENCER -- requirements
Module: sha256_avalon_sequencer

Interface
REQ-001 SHALL have parameter POLL_TIMEOUT, default 4096: maximum poll cycles per status wait (used only under SHA256_SEQ_TIMEOUT_EN).
REQ-002 SHALL have port iClk, input, 1: single clock; all state on its rising edge.
REQ-003 SHALL have port iReset_n, input, 1: asynchronous active-low reset.
REQ-004 SHALL have ports iWordValid/iWordData/iWordLast, input, 1/32/1: message word stream; iWordLast marks the final word of the message.
REQ-005 SHALL have port oWordReady, output, 1: word accepted when iWordValid && oWordReady.
REQ-006 SHALL have ports oChipSelect_n/oWrite_n/oRead_n, output, 1 each: active-low Avalon strobes to sha256_avalon_slave.
REQ-007 SHALL have ports oAddress/oData, output, 8/32: Avalon address and write data.
REQ-008 SHALL have port iData, input, 32: slave read data, combinational on current oAddress.
REQ-009 SHALL have ports oDigest/oDone/oBusy/oError, output, 256/1/1/1: final digest, one-cycle completion pulse, message in progress, sticky fault.

Function
REQ-010 SHALL use slave map: block words 0x00-0x0F, CTRL 0x10, digest 0x80-0x87; CTRL write 0x2 = START_BLOCK, 0x1 = START_LAST_BLOCK; status read at 0x10, bit0 DONE, bit3 DIGEST_UPDATE.
REQ-011 SHALL implement states IDLE, WR_BLK, START, LAST, POLL_UPD, POLL_DONE, RD_DIG, FINISH.
REQ-012 SHALL sit in IDLE with oWordReady=0 and oBusy=0, entering WR_BLK when iWordValid=1 (oBusy=1 from then until FINISH).
REQ-013 SHALL assert oWordReady only in WR_BLK; each accepted word i (0-15) issues exactly one registered write cycle next cycle: oAddress=i, oData=word, oWrite_n=0, oChipSelect_n=0; sustained one word/cycle.
REQ-014 SHALL sample iWordLast only on word 15; iWordLast on words 0-14 SHALL set oError and be otherwise ignored.
REQ-015 SHALL, after the first block of a message, go to START: one write of 0x2 to 0x10; then, if that block was last, LAST, else WR_BLK for next block.
REQ-016 SHALL, after a non-first block, go to POLL_UPD; on DIGEST_UPDATE detection, go to LAST if block was last, else WR_BLK.
REQ-017 SHALL in LAST issue one write of 0x1 to 0x10, then enter POLL_DONE.
REQ-018 SHALL poll by holding oRead_n=0, oChipSelect_n=0, oAddress=0x10 and sampling iData every cycle; first sample is baseline; detection = 0->1 transition of the watched bit between consecutive samples.
REQ-019 SHALL in RD_DIG issue 8 consecutive single-cycle reads at 0x80..0x87, capturing iData at cycle end into oDigest[255-32*i -: 32].
REQ-020 SHALL in FINISH pulse oDone for exactly one cycle, then return to IDLE; oDigest holds until the next message's RD_DIG.
REQ-021 SHALL deassert all strobes (=1) in any cycle with no bus access; never assert read and write together.
REQ-022 SHALL support unlimited blocks per message; block count tracked only as first/non-first.

Reset
REQ-023 SHALL on iReset_n=0 immediately force: state IDLE, oChipSelect_n=1, oWrite_n=1, oRead_n=1, oAddress=0, oData=0, oWordReady=0, oDigest=0, oDone=0, oBusy=0, oError=0.
REQ-024 SHALL on reset mid-message discard partial block and counters; resumes cleanly in IDLE after release.
REQ-025 SHALL clear oError only by reset.

Configuration
REQ-026 SHALL, with SHA256_SEQ_TIMEOUT_EN defined, count cycles in POLL_UPD/POLL_DONE; reaching POLL_TIMEOUT sets oError, releases strobes, returns to IDLE without oDone.
REQ-027 SHALL, without SHA256_SEQ_TIMEOUT_EN, poll indefinitely; counter logic absent.

Verification
REQ-028 Single block "abc" padded (61626380 00000000 ... 00000018) with iWordLast on word 15 -> bus: 16 writes, 0x2, 0x1, poll, 8 reads; oDigest=ba7816bf...f20015ad, one oDone pulse.
REQ-029 Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" -> START after block 1, POLL_UPD after block 2, then 0x1; oDigest=248d6a61...19db06c1.
REQ-030 Gapped iWordValid (random 0-3 idle cycles) -> identical digest; write addresses strictly 0..15 per block.
REQ-031 iWordLast on word 7 -> oError=1 sticky, message completes normally.
REQ-032 Reset asserted at word 9 of block 2 -> all outputs at reset values same cycle; next single-block message hashes correctly.
REQ-033 With SHA256_SEQ_TIMEOUT_EN, POLL_TIMEOUT=64, stub slave never sets DONE -> oError=1 after 64 poll cycles, oBusy=0, oDone never pulses.

Source files
------------

// File: rtl/sha256_avalon_sequencer.sv
// Streams message words into a sha256_avalon_slave over Avalon-MM and collects the digest.
// Optional poll watchdog: define SHA256_SEQ_TIMEOUT_EN.
module sha256_avalon_sequencer #(
    parameter int POLL_TIMEOUT = 4096
) (
    input  logic         iClk,
    input  logic         iReset_n,
    input  logic         iWordValid,
    input  logic [31:0]  iWordData,
    input  logic         iWordLast,
    output logic         oWordReady,
    output logic         oChipSelect_n,
    output logic         oWrite_n,
    output logic         oRead_n,
    output logic [7:0]   oAddress,
    output logic [31:0]  oData,
    input  logic [31:0]  iData,
    output logic [255:0] oDigest,
    output logic         oDone,
    output logic         oBusy,
    output logic         oError
);

    localparam logic [7:0]  CTRL_ADDR       = 8'h10;
    localparam logic [31:0] CMD_START_BLOCK = 32'h2;
    localparam logic [31:0] CMD_START_LAST  = 32'h1;

    if (POLL_TIMEOUT < 1) begin : g_bad_timeout
        $error("POLL_TIMEOUT must be positive");
    end

    typedef enum logic [2:0] {
        IDLE, WR_BLK, START, LAST, POLL_UPD, POLL_DONE, RD_DIG, FINISH
    } state_t;

    state_t         state, state_nxt;
    logic [3:0]     word_cnt, word_cnt_nxt;
    logic [2:0]     rd_cnt, rd_cnt_nxt;
    logic           first_blk, first_blk_nxt;
    logic           last_blk, last_blk_nxt;
    logic           have_base, have_base_nxt;
    logic           prev_bit, prev_bit_nxt;
    logic           cs_n, cs_n_nxt;
    logic           write_n, write_n_nxt;
    logic           read_n, read_n_nxt;
    logic [7:0]     addr, addr_nxt;
    logic [31:0]    data, data_nxt;
    logic [255:0]   digest, digest_nxt;
    logic           done, done_nxt;
    logic           error, error_nxt;
    logic           watch_bit;
    logic           poll_hit;
    logic [2:0]     rd_cnt_inc;
`ifdef SHA256_SEQ_TIMEOUT_EN
    logic [31:0]    poll_cnt, poll_cnt_nxt;
`endif

    // A poll sample exists only in cycles where our registered read strobe is on the bus.
    assign watch_bit  = (state == POLL_UPD) ? iData[3] : iData[0];
    assign poll_hit   = !read_n && have_base && !prev_bit && watch_bit;
    assign rd_cnt_inc = rd_cnt + 3'd1;

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        word_cnt_nxt  = word_cnt;
        rd_cnt_nxt    = rd_cnt;
        first_blk_nxt = first_blk;
        last_blk_nxt  = last_blk;
        have_base_nxt = have_base;
        prev_bit_nxt  = prev_bit;
        cs_n_nxt      = 1'b1;
        write_n_nxt   = 1'b1;
        read_n_nxt    = 1'b1;
        addr_nxt      = addr;
        data_nxt      = data;
        digest_nxt    = digest;
        done_nxt      = 1'b0;
        error_nxt     = error;
`ifdef SHA256_SEQ_TIMEOUT_EN
        poll_cnt_nxt  = '0;
`endif
        case (state)
            IDLE: begin
                if (iWordValid) begin
                    state_nxt     = WR_BLK;
                    word_cnt_nxt  = 4'd0;
                    first_blk_nxt = 1'b1;
                end
            end
            WR_BLK: begin
                if (iWordValid) begin
                    cs_n_nxt     = 1'b0;
                    write_n_nxt  = 1'b0;
                    addr_nxt     = {4'h0, word_cnt};
                    data_nxt     = iWordData;
                    word_cnt_nxt = word_cnt + 4'd1;
                    if (word_cnt != 4'd15 && iWordLast) error_nxt = 1'b1;
                    if (word_cnt == 4'd15) begin
                        last_blk_nxt  = iWordLast;
                        first_blk_nxt = 1'b0;
                        have_base_nxt = 1'b0;
                        state_nxt     = first_blk ? START : POLL_UPD;
                    end
                end
            end
            START: begin
                cs_n_nxt    = 1'b0;
                write_n_nxt = 1'b0;
                addr_nxt    = CTRL_ADDR;
                data_nxt    = CMD_START_BLOCK;
                state_nxt   = last_blk ? LAST : WR_BLK;
            end
            LAST: begin
                cs_n_nxt      = 1'b0;
                write_n_nxt   = 1'b0;
                addr_nxt      = CTRL_ADDR;
                data_nxt      = CMD_START_LAST;
                have_base_nxt = 1'b0;
                state_nxt     = POLL_DONE;
            end
            POLL_UPD, POLL_DONE: begin
                if (poll_hit) begin
                    if (state == POLL_UPD) begin
                        state_nxt = last_blk ? LAST : WR_BLK;
                    end else begin
                        state_nxt  = RD_DIG;
                        cs_n_nxt   = 1'b0;
                        read_n_nxt = 1'b0;
                        addr_nxt   = 8'h80;
                        rd_cnt_nxt = 3'd0;
                    end
                end else begin
                    cs_n_nxt   = 1'b0;
                    read_n_nxt = 1'b0;
                    addr_nxt   = CTRL_ADDR;
                    if (!read_n) begin
                        have_base_nxt = 1'b1;
                        prev_bit_nxt  = watch_bit;
                    end
`ifdef SHA256_SEQ_TIMEOUT_EN
                    if (poll_cnt == 32'(POLL_TIMEOUT - 1)) begin
                        error_nxt  = 1'b1;
                        cs_n_nxt   = 1'b1;
                        read_n_nxt = 1'b1;
                        state_nxt  = IDLE;
                    end else begin
                        poll_cnt_nxt = poll_cnt + 32'd1;
                    end
`endif
                end
            end
            RD_DIG: begin
                for (int i = 0; i < 8; i++) begin
                    if (rd_cnt == 3'(i)) digest_nxt[255 - 32*i -: 32] = iData;
                end
                if (rd_cnt == 3'd7) begin
                    state_nxt = FINISH;
                    done_nxt  = 1'b1;
                end else begin
                    cs_n_nxt   = 1'b0;
                    read_n_nxt = 1'b0;
                    addr_nxt   = {5'b10000, rd_cnt_inc};
                    rd_cnt_nxt = rd_cnt_inc;
                end
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            word_cnt  <= '0;
            rd_cnt    <= '0;
            first_blk <= 1'b0;
            last_blk  <= 1'b0;
            have_base <= 1'b0;
            prev_bit  <= 1'b0;
            cs_n      <= 1'b1;
            write_n   <= 1'b1;
            read_n    <= 1'b1;
            addr      <= '0;
            data      <= '0;
            digest    <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
`ifdef SHA256_SEQ_TIMEOUT_EN
            poll_cnt  <= '0;
`endif
        end else begin
            word_cnt  <= word_cnt_nxt;
            rd_cnt    <= rd_cnt_nxt;
            first_blk <= first_blk_nxt;
            last_blk  <= last_blk_nxt;
            have_base <= have_base_nxt;
            prev_bit  <= prev_bit_nxt;
            cs_n      <= cs_n_nxt;
            write_n   <= write_n_nxt;
            read_n    <= read_n_nxt;
            addr      <= addr_nxt;
            data      <= data_nxt;
            digest    <= digest_nxt;
            done      <= done_nxt;
            error     <= error_nxt;
`ifdef SHA256_SEQ_TIMEOUT_EN
            poll_cnt  <= poll_cnt_nxt;
`endif
        end
    end

    assign oWordReady    = (state == WR_BLK);
    assign oBusy         = (state != IDLE);
    assign oChipSelect_n = cs_n;
    assign oWrite_n      = write_n;
    assign oRead_n       = read_n;
    assign oAddress      = addr;
    assign oData         = data;
    assign oDigest       = digest;
    assign oDone         = done;
    assign oError        = error;

endmodule

// File: tb/tb_sha256_avalon_sequencer.sv
// Bench for sha256_avalon_sequencer: behavioural SHA-256 slave stub, known-answer table,
// random multi-block messages against a plain SHA-256 chaining model, reset and timeout cases.
module tb_sha256_avalon_sequencer;

    logic         iClk = 1'b0;
    logic         iReset_n = 1'b0;
    logic         iWordValid = 1'b0;
    logic [31:0]  iWordData = '0;
    logic         iWordLast = 1'b0;
    logic         oWordReady;
    logic         oChipSelect_n, oWrite_n, oRead_n;
    logic [7:0]   oAddress;
    logic [31:0]  oData;
    logic [31:0]  iData;
    logic [255:0] oDigest;
    logic         oDone, oBusy, oError;

    sha256_avalon_sequencer #(.POLL_TIMEOUT(64)) dut (
        .iClk(iClk), .iReset_n(iReset_n),
        .iWordValid(iWordValid), .iWordData(iWordData), .iWordLast(iWordLast),
        .oWordReady(oWordReady),
        .oChipSelect_n(oChipSelect_n), .oWrite_n(oWrite_n), .oRead_n(oRead_n),
        .oAddress(oAddress), .oData(oData), .iData(iData),
        .oDigest(oDigest), .oDone(oDone), .oBusy(oBusy), .oError(oError)
    );

    always #5 iClk = ~iClk;

    localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] ABC_DIG = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] TWO_DIG = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // FIPS 180-4 compression of one 512-bit block onto chaining value h.
    function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++)
            w[t] = w[t-16] + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-7]
                 + (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10));
        {a, b, c, d, e, f, g, hh} = h;
        for (int t = 0; t < 64; t++) begin
            t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
                h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
    endfunction

    logic [31:0] msg [$];

    function automatic logic [255:0] model_digest(input int nb);
        logic [255:0] h = IV;
        logic [511:0] blk;
        for (int b = 0; b < nb; b++) begin
            for (int w = 0; w < 16; w++) blk[511 - 32*w -: 32] = msg[b*16 + w];
            h = sha_compress(h, blk);
        end
        return h;
    endfunction

    // ---------------- slave stub ----------------
    logic [31:0]  blk_mem [16];
    logic [255:0] s_h = '0;
    logic         s_upd, s_done, chained;
    int           upd_tmr, done_tmr;
    bit           never_done = 1'b0;

    function automatic logic [511:0] pack_blk(input logic [31:0] w15);
        logic [511:0] r;
        for (int i = 0; i < 15; i++) r[511 - 32*i -: 32] = blk_mem[i];
        r[31:0] = w15;
        return r;
    endfunction

    always_comb begin
        iData = '0;
        if (oAddress == 8'h10) iData = {28'h0, s_upd, 2'b00, s_done};
        else if (oAddress < 8'h10) iData = blk_mem[oAddress[3:0]];
        else if (oAddress[7:3] == 5'b10000) begin
            for (int i = 0; i < 8; i++)
                if (oAddress[2:0] == 3'(i)) iData = s_h[255 - 32*i -: 32];
        end
    end

    always @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            s_upd <= 1'b0; s_done <= 1'b0; chained <= 1'b0; upd_tmr <= 0; done_tmr <= 0;
        end else begin
            if (upd_tmr > 0) begin upd_tmr <= upd_tmr - 1; if (upd_tmr == 1) s_upd <= 1'b1; end
            if (done_tmr > 0) begin done_tmr <= done_tmr - 1; if (done_tmr == 1) s_done <= 1'b1; end
            if (!oChipSelect_n && !oWrite_n) begin
                if (oAddress < 8'h10) begin
                    blk_mem[oAddress[3:0]] <= oData;
                    if (oAddress == 8'h0F && chained) begin
                        s_h     <= sha_compress(s_h, pack_blk(oData));
                        s_upd   <= 1'b0;
                        upd_tmr <= int'($urandom_range(6, 1));
                    end
                end else if (oAddress == 8'h10 && oData == 32'h2) begin
                    s_h     <= sha_compress(IV, pack_blk(blk_mem[15]));
                    chained <= 1'b1;
                end else if (oAddress == 8'h10 && oData == 32'h1) begin
                    s_done   <= 1'b0;
                    done_tmr <= never_done ? 0 : int'($urandom_range(6, 1));
                    chained  <= 1'b0;
                end
            end
        end
    end

    // ---------------- bus monitor ----------------
    logic [39:0] wlog [$];
    logic [7:0]  rlog [$];
    int          done_total = 0;
    int          coll_total = 0;

    always @(negedge iClk) begin
        if (!oChipSelect_n && !oWrite_n) wlog.push_back({oAddress, oData});
        if (!oChipSelect_n && !oRead_n && oAddress[7]) rlog.push_back(oAddress);
        if (oDone) done_total <= done_total + 1;
        if (!oRead_n && !oWrite_n) coll_total <= coll_total + 1;
    end

    // ---------------- checking ----------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_strobes"}, {oChipSelect_n, oWrite_n, oRead_n, oAddress, oData,
                                   oWordReady, oDone, oBusy, oError},
              {3'b111, 8'h00, 32'h0, 4'b0000});
        check({name, "_digest"}, oDigest, '0);
    endtask

    task automatic apply_reset();
        iWordValid = 1'b0;
        iWordLast  = 1'b0;
        iReset_n   = 1'b0;
        repeat (2) @(posedge iClk);
        #1;
        check_reset_outputs("reset");
        @(negedge iClk);
        iReset_n = 1'b1;
        @(posedge iClk);
        #1;
    endtask

    task automatic send_words(input int first, input int count, input int gap_max,
                              input int err_idx, output bit all_acc);
        bit acc;
        all_acc = 1'b1;
        for (int i = first; i < first + count; i++) begin
            int g;
            g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            iWordValid = 1'b0;
            repeat (g) begin @(posedge iClk); #1; end
            iWordValid = 1'b1;
            iWordData  = msg[i];
            iWordLast  = (i == msg.size() - 1) || (i == err_idx);
            acc = 1'b0;
            for (int c = 0; c < 200 && !acc; c++) begin
                @(negedge iClk);
                acc = oWordReady;
                @(posedge iClk);
                #1;
            end
            if (!acc) all_acc = 1'b0;
        end
        iWordValid = 1'b0;
        iWordLast  = 1'b0;
    endtask

    function automatic bit wmatch(input int idx, input logic [39:0] v);
        return (idx < wlog.size()) && (wlog[idx] == v);
    endfunction

    task automatic run_msg(input string tag, input int nb, input int gap_max, input int err_idx,
                           input logic [255:0] exp_dig, input logic exp_err);
        int ws, rs, ds, cs, wi;
        bit acc, seen, ok;
        ws = wlog.size(); rs = rlog.size(); ds = done_total; cs = coll_total;
        send_words(0, nb * 16, gap_max, err_idx, acc);
        check({tag, "_accept"}, acc, 1);
        seen = 1'b0;
        for (int c = 0; c < 3000 && !seen; c++) begin
            @(posedge iClk);
            #2;
            seen = (done_total != ds);
        end
        repeat (3) @(posedge iClk);
        #2;
        check({tag, "_digest"}, oDigest, exp_dig);
        check({tag, "_done_pulses"}, done_total - ds, 1);
        check({tag, "_error"}, oError, exp_err);
        check({tag, "_busy_after"}, oBusy, 0);
        ok = 1'b1;
        wi = ws;
        for (int b = 0; b < nb; b++) begin
            for (int w = 0; w < 16; w++) begin
                if (!wmatch(wi, {8'(w), msg[b*16 + w]})) ok = 1'b0;
                wi++;
            end
            if (b == 0) begin
                if (!wmatch(wi, {8'h10, 32'h2})) ok = 1'b0;
                wi++;
            end
        end
        if (!wmatch(wi, {8'h10, 32'h1})) ok = 1'b0;
        wi++;
        if (wlog.size() != wi) ok = 1'b0;
        check({tag, "_write_seq"}, ok, 1);
        ok = (rlog.size() == rs + 8);
        for (int i = 0; i < 8 && ok; i++) if (rlog[rs + i] != 8'h80 + 8'(i)) ok = 1'b0;
        check({tag, "_digest_reads"}, ok, 1);
        check({tag, "_no_collision"}, coll_total - cs, 0);
    endtask

    task automatic load_abc();
        msg.delete();
        msg.push_back(32'h61626380);
        repeat (14) msg.push_back(32'h0);
        msg.push_back(32'h00000018);
    endtask

    task automatic load_two();
        logic [31:0] tw [14] = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                 32'h6d6e6f70, 32'h6e6f7071};
        msg.delete();
        for (int i = 0; i < 14; i++) msg.push_back(tw[i]);
        msg.push_back(32'h80000000);
        repeat (16) msg.push_back(32'h0);
        msg.push_back(32'h000001c0);
    endtask

    typedef struct {
        string        tag;
        bit           two_blk;
        int           gap_max;
        int           err_idx;
        logic [255:0] exp_dig;
        logic         exp_err;
    } vec_t;

    initial begin
        vec_t vecs [5];
        vecs[0] = '{"abc",        1'b0, 0, -1, ABC_DIG, 1'b0};
        vecs[1] = '{"two_blk",    1'b1, 0, -1, TWO_DIG, 1'b0};
        vecs[2] = '{"abc_gap",    1'b0, 3, -1, ABC_DIG, 1'b0};
        vecs[3] = '{"two_gap",    1'b1, 3, -1, TWO_DIG, 1'b0};
        vecs[4] = '{"abc_last7",  1'b0, 0,  7, ABC_DIG, 1'b1};

        apply_reset();
        for (int v = 0; v < 5; v++) begin
            if (vecs[v].two_blk) load_two();
            else                 load_abc();
            run_msg(vecs[v].tag, vecs[v].two_blk ? 2 : 1, vecs[v].gap_max, vecs[v].err_idx,
                    vecs[v].exp_dig, vecs[v].exp_err);
        end

        apply_reset();
        for (int r = 0; r < 4; r++) begin
            int nb;
            nb = int'($urandom_range(3, 1));
            msg.delete();
            for (int i = 0; i < nb * 16; i++) msg.push_back($urandom);
            run_msg($sformatf("rand%0d", r), nb, int'($urandom_range(2, 0)), -1,
                    model_digest(nb), 1'b0);
        end

        // Reset while word 9 of block 2 is being offered.
        begin
            bit acc;
            load_two();
            send_words(0, 25, 0, -1, acc);
            check("midreset_accept", acc, 1);
            iWordValid = 1'b1;
            iWordData  = msg[25];
            @(negedge iClk);
            iReset_n = 1'b0;
            #1;
            check_reset_outputs("midreset");
            iWordValid = 1'b0;
            @(negedge iClk);
            iReset_n = 1'b1;
            @(posedge iClk);
            #1;
            load_abc();
            run_msg("post_reset_abc", 1, 0, -1, ABC_DIG, 1'b0);
        end

`ifdef SHA256_SEQ_TIMEOUT_EN
        begin
            bit acc, idle;
            int ds;
            apply_reset();
            never_done = 1'b1;
            load_abc();
            ds = done_total;
            send_words(0, 16, 0, -1, acc);
            idle = 1'b0;
            for (int c = 0; c < 1000 && !idle; c++) begin
                @(posedge iClk);
                #2;
                idle = !oBusy;
            end
            check("timeout_idle", idle, 1);
            check("timeout_error", oError, 1);
            check("timeout_no_done", done_total - ds, 0);
            never_done = 1'b0;
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
